// File: rtl/uart_tx_sched_if.sv
// Requester-side handshake bundle for uart_tx_sched: two byte sources, each
// with a held request, stable data and a one-cycle accept pulse.
interface uart_tx_sched_if;
   logic       req0;
   logic [7:0] data0;
   logic       req1;
   logic [7:0] data1;
   logic       ack0;
   logic       ack1;

   modport master (output req0, data0, req1, data1, input ack0, ack1);
   modport slave  (input req0, data0, req1, data1, output ack0, ack1);
endinterface

// File: rtl/uart_tx_sched.sv
// UART transmit framer that shares one PISO shifter between two requesters,
// round-robin, emitting start / 8 data LSB-first / optional parity / stop bits.
module uart_tx_sched #(
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic             slow_baud_clk,
   input  logic             reset,
   uart_tx_sched_if.slave   req_bus,
   output logic [7:0]       piso_data,
   output logic             piso_load,
   output logic             piso_shift,
   input  logic             piso_bit,
   output logic             tx,
   output logic             busy,
   output logic             active_src
);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic STOP_LAST      = (STOP_BITS == 2);
   localparam logic PARITY_ODD_BIT = (PARITY_ODD != 0);

   state_t          state_reg;
   logic [2:0]      bit_cnt_reg;
   logic            stop_cnt_reg;
   logic            last_grant_reg;
   logic            parity_reg;
   logic            active_src_reg;

   logic [1:0]      req_vec;
   logic [1:0]      ack_vec;
   logic [1:0][7:0] data_vec;
   logic            grant_win;
   logic            grant_any;
   logic            winner;
   logic [7:0]      sel_byte;

   assign req_vec  = {req_bus.req1, req_bus.req0};
   assign data_vec = {req_bus.data1, req_bus.data0};

   // Grants happen only when idle or on the last stop bit, which lets frames
   // run back-to-back; gating with reset keeps acks quiet while held in reset.
   assign grant_win = reset && ((state_reg == IDLE) ||
                                ((state_reg == STOP) && (stop_cnt_reg == STOP_LAST)));
   assign grant_any = grant_win && (|req_vec);
   assign winner    = (&req_vec) ? ~last_grant_reg : req_vec[1];
   assign sel_byte  = data_vec[winner];

   for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_vec[gi] = grant_any && (winner == (gi == 1));
   end

   assign req_bus.ack0 = ack_vec[0];
   assign req_bus.ack1 = ack_vec[1];
   assign piso_load    = grant_any;
   assign piso_data    = grant_any ? sel_byte : 8'h00;
   assign active_src   = active_src_reg;

   always_comb begin
      tx         = 1'b1;
      busy       = 1'b1;
      piso_shift = 1'b0;
      case (state_reg)
         IDLE:    busy = 1'b0;
         START:   tx = 1'b0;
         DATA: begin
            tx         = piso_bit;
            piso_shift = 1'b1;
         end
         PARITY:  tx = parity_reg;
         STOP:    tx = 1'b1;
         default: busy = 1'b0;
      endcase
   end

   always_ff @(posedge slow_baud_clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         bit_cnt_reg    <= 3'd0;
         stop_cnt_reg   <= 1'b0;
         last_grant_reg <= 1'b1;
         parity_reg     <= 1'b0;
         active_src_reg <= 1'b0;
      end else if (grant_any) begin
         state_reg      <= START;
         bit_cnt_reg    <= 3'd0;
         last_grant_reg <= winner;
         active_src_reg <= winner;
         parity_reg     <= (^sel_byte) ^ PARITY_ODD_BIT;
      end else begin
         case (state_reg)
            IDLE:  state_reg <= IDLE;
            START: begin
               state_reg   <= DATA;
               bit_cnt_reg <= 3'd0;
            end
            DATA: begin
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == 3'd7) begin
                  state_reg    <= (PARITY_EN != 0) ? PARITY : STOP;
                  stop_cnt_reg <= 1'b0;
               end
            end
            PARITY: begin
               state_reg    <= STOP;
               stop_cnt_reg <= 1'b0;
            end
            STOP: begin
               if (stop_cnt_reg == STOP_LAST)
                  state_reg <= IDLE;
               else
                  stop_cnt_reg <= stop_cnt_reg + 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Transmit controller and arbiter for the 8-bit UART PISO shifter; one slow_baud_clk cycle equals one bit time.
- Shares the single shifter between two byte requesters using round-robin.
- Drives the shifter's load and shift strobes and parallel data, and frames the serial line: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
- Sits between the host-side byte sources and the shifter/line driver.

Parameters:
- PARITY_EN, 0: 1 = insert parity bit after data.
- PARITY_ODD, 0: 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits, 1 or 2.

Ports:
- slow_baud_clk  in  1  bit-rate clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req0  in  1  requester 0 has a byte; held until ack0.
- data0  in  8  requester 0 byte; stable while req0=1.
- req1  in  1  requester 1 has a byte; held until ack1.
- data1  in  8  requester 1 byte; stable while req1=1.
- ack0  out  1  one-cycle grant/accept pulse to requester 0.
- ack1  out  1  one-cycle grant/accept pulse to requester 1.
- piso_data  out  8  byte presented to the shifter's parallel input.
- piso_load  out  1  shifter load strobe.
- piso_shift  out  1  shifter shift-right strobe.
- piso_bit  in  1  shifter LSB (its data_bit output).
- tx  out  1  serial line, idle high.
- busy  out  1  1 from START through final STOP.
- active_src  out  1  source of the current/last frame (0 or 1).

Behaviour:
- Reset (async, reset=0):
  - state=IDLE; bit counter=0; stop counter=0; last_grant=1 (so req0 wins first); parity reg=0; active_src=0.
  - Outputs: tx=1, ack0=ack1=0, piso_load=0, piso_shift=0, busy=0, piso_data=0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- Grant window: IDLE, or the final STOP cycle (stop counter = STOP_BITS-1).
  - In a grant window with any req high, the arbiter picks a source combinationally:
    - only one requester high -> that one;
    - both high -> the one not equal to last_grant.
  - In that same cycle: piso_load=1, piso_data=selected byte, ack of the winner=1.
  - On the next edge: last_grant and active_src <= winner; parity reg <= XOR of the byte, XORed with PARITY_ODD; state <= START.
  - No request in a grant window: piso_load=0, piso_data=0, state stays/returns IDLE.
- IDLE: tx=1, busy=0.
- START: tx=0, busy=1, piso_shift=0; next state DATA with bit counter=0.
- DATA: tx=piso_bit, piso_shift=1.
  - Bit counter increments each cycle.
  - After the cycle with counter=7: go to PARITY if PARITY_EN, else STOP.
  - Result is exactly 8 data bit times, LSB first.
- PARITY: tx=parity reg, piso_shift=0; next state STOP.
- STOP: tx=1, busy=1, piso_shift=0.
  - Lasts STOP_BITS cycles via the stop counter.
  - Final cycle is a grant window. If granted, next state is START (back-to-back frames, no idle gap); otherwise IDLE.
- piso_load and piso_shift are never high together.
- ack is never asserted outside a grant window, and at most one ack is asserted per cycle.
- A req that drops before its ack is simply not served; no error is flagged.
- Frame length, from load edge to end of last stop bit: 1 + 8 + PARITY_EN + STOP_BITS cycles.

Test Plan:
- Reset, then req0=1, data0=0x55 (default params) -> ack0 and piso_load pulse in the same cycle. Following cycles: tx = 0, then 1,0,1,0,1,0,1,0, then 1; busy high for 10 cycles; active_src=0.
- req0 and req1 both held continuously, data0=0xA0, data1=0x0F -> grants alternate 0,1,0,1. Frames are back-to-back with no idle cycle between stop and the next start bit.
- PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1. With PARITY_ODD=1, parity bit 0. STOP_BITS=2 gives two high stop cycles; frame is 12 cycles total.
- Reset asserted during DATA bit 4 -> tx=1, busy=0, piso_shift=0 immediately. After release, a new req1 gives a clean full frame with ack1.
- req1 only, asserted mid-frame of a req0 transfer -> ack1 occurs only in the final STOP cycle. No ack pulse in any other cycle. piso_load and piso_shift are never both 1.
- Idle line with no requests for 20 cycles -> tx=1, busy=0, no strobes; then a single byte 0xFF -> tx = 0, then eight 1s, then stop 1.
